// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer: state encoding,
// instruction classes, opcode values and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  // Execution flavour after fetch; C_NOP also covers undefined opcodes.
  typedef enum logic [2:0] {
    C_NOP,
    C_RR,
    C_IMM,
    C_LD,
    C_ST,
    C_HALT
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_INC  = 5'b01111;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: run/ir/mem_rdy
// flow into the sequencer, all control strobes flow out.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        Pout;
  logic        MARen;
  logic        Pen;
  logic        Read;
  logic        Write;
  logic        MDRen;
  logic        MDROut;
  logic        IRen;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        Cout;
  logic        Yen;
  logic        ZLOen;
  logic        ZLOout;
  logic [4:0]  alu_control;
  logic        halted;

  modport master (
    input  run, ir, mem_rdy,
    output Pout, MARen, Pen, Read, Write, MDRen, MDROut, IRen,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout,
           alu_control, halted
  );

  modport slave (
    output run, ir, mem_rdy,
    input  Pout, MARen, Pen, Read, Write, MDRen, MDROut, IRen,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout,
           alu_control, halted
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps the 5-bit opcode to an instruction class and the
// ALU operation used in the execute step.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic [4:0] alu_op
);

  // Pure table lookup from opcode to class and ALU code.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    iclass = C_NOP;
    alu_op = ALU_NONE;
    unique case (opcode)
      OP_ADD:  begin iclass = C_RR;   alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = C_RR;   alu_op = ALU_SUB; end
      OP_AND:  begin iclass = C_RR;   alu_op = ALU_AND; end
      OP_OR:   begin iclass = C_RR;   alu_op = ALU_OR;  end
      OP_ADDI: begin iclass = C_IMM;  alu_op = ALU_ADD; end
      OP_ANDI: begin iclass = C_IMM;  alu_op = ALU_AND; end
      OP_ORI:  begin iclass = C_IMM;  alu_op = ALU_OR;  end
      OP_LD:   begin iclass = C_LD;   alu_op = ALU_ADD; end
      OP_ST:   begin iclass = C_ST;   alu_op = ALU_ADD; end
      OP_HALT: iclass = C_HALT;
      default: iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then class-dependent execute
// (T3-T7), plus IDLE and HALT. Define CTRL_MEMWAIT_EN to stretch T1,
// LD-T6 and ST-T7 until mem_rdy is sampled high.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic clr,
  control_sequencer_if.master bus
);

  state_t     state;
  state_t     state_n;
  iclass_t    iclass;
  logic [4:0] alu_op;
  logic       mem_done;
  logic [26:0] ir_unused;

  assign ir_unused = bus.ir[26:0];

`ifdef CTRL_MEMWAIT_EN
  assign mem_done = bus.mem_rdy;
`else
  logic mem_rdy_unused;
  assign mem_rdy_unused = bus.mem_rdy;
  assign mem_done = 1'b1;
`endif

  ctrl_decode u_decode (
    .opcode (opcode_of(bus.ir)),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  // State register; clr forces IDLE at once, independent of the clock.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (clr) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (bus.run) state_n = S_T0;
      S_T0:   state_n = S_T1;
      S_T1:   if (mem_done) state_n = S_T2;
      S_T2: begin
        unique case (iclass)
          C_RR, C_IMM, C_LD, C_ST: state_n = S_T3;
          C_HALT:                  state_n = S_HALT;
          default:                 state_n = S_T0;
        endcase
      end
      S_T3:   state_n = S_T4;
      S_T4:   state_n = S_T5;
      S_T5:   state_n = (iclass == C_LD || iclass == C_ST) ? S_T6 : S_T0;
      S_T6:   if (iclass == C_ST || mem_done) state_n = S_T7;
      S_T7:   if (iclass == C_LD || mem_done) state_n = S_T0;
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode from present state and instruction class.
  always_comb begin
    bus.Pout = 1'b0;  bus.MARen = 1'b0;  bus.Pen = 1'b0;    bus.Read = 1'b0;
    bus.Write = 1'b0; bus.MDRen = 1'b0;  bus.MDROut = 1'b0; bus.IRen = 1'b0;
    bus.Gra = 1'b0;   bus.Grb = 1'b0;    bus.Grc = 1'b0;    bus.Rin = 1'b0;
    bus.Rout = 1'b0;  bus.BAout = 1'b0;  bus.Cout = 1'b0;   bus.Yen = 1'b0;
    bus.ZLOen = 1'b0; bus.ZLOout = 1'b0; bus.halted = 1'b0;
    bus.alu_control = ALU_NONE;
    unique case (state)
      S_T0: begin
        bus.Pout = 1'b1; bus.MARen = 1'b1; bus.ZLOen = 1'b1;
        bus.alu_control = ALU_INC;
      end
      S_T1: begin
        bus.ZLOout = 1'b1; bus.Pen = 1'b1; bus.Read = 1'b1; bus.MDRen = 1'b1;
      end
      S_T2: begin
        bus.MDROut = 1'b1; bus.IRen = 1'b1;
      end
      S_T3: begin
        if (iclass == C_RR || iclass == C_IMM) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yen = 1'b1;
        end else if (iclass == C_LD || iclass == C_ST) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yen = 1'b1;
        end
      end
      S_T4: begin
        if (iclass == C_RR) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOen = 1'b1;
          bus.alu_control = alu_op;
        end else if (iclass == C_IMM || iclass == C_LD || iclass == C_ST) begin
          bus.Cout = 1'b1; bus.ZLOen = 1'b1;
          bus.alu_control = alu_op;
        end
      end
      S_T5: begin
        if (iclass == C_RR || iclass == C_IMM) begin
          bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (iclass == C_LD || iclass == C_ST) begin
          bus.ZLOout = 1'b1; bus.MARen = 1'b1;
        end
      end
      S_T6: begin
        if (iclass == C_LD) begin
          bus.Read = 1'b1; bus.MDRen = 1'b1;
        end else if (iclass == C_ST) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRen = 1'b1;
        end
      end
      S_T7: begin
        if (iclass == C_LD) begin
          bus.MDROut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (iclass == C_ST) begin
          bus.Write = 1'b1;
        end
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process pushes the
// expected output word for each cycle; a monitor pops and compares it.
module tb_control_sequencer;

  logic clk;
  logic clr;

  control_sequencer_if bus();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout: [23:19] alu_control, [18] halted, [17:0] strobes.
  localparam logic [23:0] B_POUT   = 24'h1 << 0;
  localparam logic [23:0] B_MAREN  = 24'h1 << 1;
  localparam logic [23:0] B_PEN    = 24'h1 << 2;
  localparam logic [23:0] B_READ   = 24'h1 << 3;
  localparam logic [23:0] B_WRITE  = 24'h1 << 4;
  localparam logic [23:0] B_MDREN  = 24'h1 << 5;
  localparam logic [23:0] B_MDROUT = 24'h1 << 6;
  localparam logic [23:0] B_IREN   = 24'h1 << 7;
  localparam logic [23:0] B_GRA    = 24'h1 << 8;
  localparam logic [23:0] B_GRB    = 24'h1 << 9;
  localparam logic [23:0] B_GRC    = 24'h1 << 10;
  localparam logic [23:0] B_RIN    = 24'h1 << 11;
  localparam logic [23:0] B_ROUT   = 24'h1 << 12;
  localparam logic [23:0] B_BAOUT  = 24'h1 << 13;
  localparam logic [23:0] B_COUT   = 24'h1 << 14;
  localparam logic [23:0] B_YEN    = 24'h1 << 15;
  localparam logic [23:0] B_ZLOEN  = 24'h1 << 16;
  localparam logic [23:0] B_ZLOOUT = 24'h1 << 17;
  localparam logic [23:0] B_HALTED = 24'h1 << 18;

  function automatic logic [23:0] alu(input logic [4:0] c);
    return {c, 19'b0};
  endfunction

  // Hand-derived expected words for each step.
  localparam logic [23:0] E_ZERO = 24'h0;
  localparam logic [23:0] E_T0   = B_POUT | B_MAREN | B_ZLOEN | (24'h0F << 19);
  localparam logic [23:0] E_T1   = B_ZLOOUT | B_PEN | B_READ | B_MDREN;
  localparam logic [23:0] E_T2   = B_MDROUT | B_IREN;
  localparam logic [23:0] E_T3R  = B_GRB | B_ROUT | B_YEN;
  localparam logic [23:0] E_T5R  = B_ZLOOUT | B_GRA | B_RIN;
  localparam logic [23:0] E_T3M  = B_GRB | B_BAOUT | B_YEN;
  localparam logic [23:0] E_T5M  = B_ZLOOUT | B_MAREN;

  logic [23:0] act;
  assign act = {bus.alu_control, bus.halted, bus.ZLOout, bus.ZLOen, bus.Yen,
                bus.Cout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb,
                bus.Gra, bus.IRen, bus.MDROut, bus.MDRen, bus.Write, bus.Read,
                bus.Pen, bus.MARen, bus.Pout};

  typedef struct {
    logic [23:0] exp;
    int          id;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       step_id = 0;
  int       n_checks = 0;
  int       n_pass = 0;
  event     chk_ev;

  task automatic push(input logic [23:0] e);
    sb_item_t it;
    it.exp = e;
    it.id  = step_id;
    sb_q.push_back(it);
    step_id++;
  endtask

  // One clock: expectation for the state entered at this rising edge.
  task automatic step(input logic [23:0] e);
    @(posedge clk);
    #1;
    push(e);
  endtask

  // Mid-cycle clr pulse; outputs must be zero before the next edge.
  task automatic clr_pulse();
    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    push(E_ZERO);
    -> chk_ev;
    #1 clr = 1'b0;
  endtask

  // Monitor: compares on the falling edge, or immediately on request.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk or chk_ev);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        n_checks++;
        if (act === it.exp) n_pass++;
        else $display("FAIL step%0d outputs: got %h expected %h", it.id, act, it.exp);
      end
    end
  end

  initial begin
    clr = 1'b1;
    bus.run = 1'b0;
    bus.ir = 32'h0;
`ifdef CTRL_MEMWAIT_EN
    bus.mem_rdy = 1'b1;
`else
    bus.mem_rdy = 1'b0;
`endif
    #2;
    push(E_ZERO);
    -> chk_ev;
    #10 clr = 1'b0;

    // IDLE holds while run is low.
    step(E_ZERO);
    step(E_ZERO);

    // andi R2,R4,0x71; run dropped after T0 must not abort.
    bus.ir = 32'h69200071;
    bus.run = 1'b1;
    step(E_T0);
    bus.run = 1'b0;
    step(E_T1);
    step(E_T2);
    step(E_T3R);
    step(B_COUT | B_ZLOEN | alu(5'b00011));
    step(E_T5R);
    step(E_T0);

    // sub (reg-reg)
    bus.ir = 32'h20000000;
    step(E_T1);
    step(E_T2);
    step(E_T3R);
    step(B_GRC | B_ROUT | B_ZLOEN | alu(5'b00010));
    step(E_T5R);
    step(E_T0);

    // ld
    bus.ir = 32'h00000000;
    step(E_T1);
    step(E_T2);
    step(E_T3M);
    step(B_COUT | B_ZLOEN | alu(5'b00001));
    step(E_T5M);
    step(B_READ | B_MDREN);
    step(B_MDROUT | B_GRA | B_RIN);
    step(E_T0);

    // st
    bus.ir = 32'h10000000;
    step(E_T1);
    step(E_T2);
    step(E_T3M);
    step(B_COUT | B_ZLOEN | alu(5'b00001));
    step(E_T5M);
    step(B_GRA | B_ROUT | B_MDREN);
    step(B_WRITE);
    step(E_T0);

    // undefined opcode 10111 then nop 11010: straight back to T0
    bus.ir = 32'hB8000000;
    step(E_T1);
    step(E_T2);
    step(E_T0);
    bus.ir = 32'hD0000000;
    step(E_T1);
    step(E_T2);
    step(E_T0);

    // or (reg-reg), then add interrupted by clr in T4
    bus.ir = 32'h30000000;
    step(E_T1);
    step(E_T2);
    step(E_T3R);
    step(B_GRC | B_ROUT | B_ZLOEN | alu(5'b00100));
    step(E_T5R);
    step(E_T0);
    bus.ir = 32'h18000000;
    step(E_T1);
    step(E_T2);
    step(E_T3R);
    step(B_GRC | B_ROUT | B_ZLOEN | alu(5'b00001));
    clr_pulse();
    step(E_ZERO);

    // halt: stays halted with run toggling, clr returns to IDLE
    bus.ir = 32'hD8000000;
    bus.run = 1'b1;
    step(E_T0);
    bus.run = 1'b0;
    step(E_T1);
    step(E_T2);
    for (int i = 0; i < 20; i++) begin
      step(B_HALTED);
      bus.run = ~bus.run;
    end
    bus.run = 1'b0;
    clr_pulse();
    step(E_ZERO);

`ifdef CTRL_MEMWAIT_EN
    // mem_rdy low for three sampled edges in T1 stretches it to four cycles
    bus.ir = 32'h69200071;
    bus.run = 1'b1;
    step(E_T0);
    bus.run = 1'b0;
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) step(E_T1);
    bus.mem_rdy = 1'b1;
    step(E_T2);
    step(E_T3R);
    clr_pulse();
    step(E_ZERO);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-high.
REQ-003 run  in  1  start/continue; IDLE leaves to T0 only when high.
REQ-004 ir  in  32  IR contents from datapath; opcode ir[31:27].
REQ-005 mem_rdy  in  1  memory access complete (used only with CTRL_MEMWAIT_EN).
REQ-006 Pout  out  1  PC drives bus.
REQ-007 MARen  out  1  MAR load.
REQ-008 Pen  out  1  PC load.
REQ-009 Read  out  1  memory read / MDR source select.
REQ-010 Write  out  1  memory write.
REQ-011 MDRen  out  1  MDR load.
REQ-012 MDROut  out  1  MDR drives bus.
REQ-013 IRen  out  1  IR load.
REQ-014 Gra, Grb, Grc  out  1 each  register-field selects (one line per port in RTL).
REQ-015 Rin  out  1  selected register load.
REQ-016 Rout  out  1  selected register drives bus.
REQ-017 BAout  out  1  base-address register out (R0 reads as 0).
REQ-018 Cout  out  1  sign-extended constant drives bus.
REQ-019 Yen  out  1  Y load.
REQ-020 ZLOen  out  1  Z low load.
REQ-021 ZLOout  out  1  Z low drives bus.
REQ-022 alu_control  out  5  ALU operation code.
REQ-023 halted  out  1  high while in HALT.

Function
REQ-024 SHALL be Moore: every output a pure decode of present state and ir; one state per clock.
REQ-025 SHALL implement states IDLE, T0..T7, HALT; IDLE->T0 when run=1, else stay IDLE.
REQ-026 Fetch SHALL be T0: Pout,MARen,ZLOen,alu_control=INC; T1: ZLOout,Pen,Read,MDRen; T2: MDROut,IRen.
REQ-027 After T2: ADD/SUB/AND/OR (00011/00100/00101/00110) and ADDI/ANDI/ORI (01100/01101/01110) -> T3; LD 00000, ST 00010 -> T3; NOP 11010 and undefined opcodes -> T0 (nop); HALT 11011 -> HALT.
REQ-028 Reg-reg: T3 Grb,Rout,Yen; T4 Grc,Rout,ZLOen,alu op; T5 ZLOout,Gra,Rin; T5->T0 (6 cycles total).
REQ-029 Immediate: T3 Grb,Rout,Yen; T4 Cout,ZLOen,alu op; T5 ZLOout,Gra,Rin; T5->T0.
REQ-030 LD/ST address: T3 Grb,BAout,Yen; T4 Cout,ZLOen,ADD; T5 ZLOout,MARen.
REQ-031 LD: T6 Read,MDRen; T7 MDROut,Gra,Rin; T7->T0 (8 cycles). ST: T6 Gra,Rout,MDRen (Read=0); T7 Write; T7->T0.
REQ-032 run is sampled only in IDLE; deassertion mid-instruction SHALL NOT abort it.
REQ-033 HALT SHALL hold all strobes low, halted=1, until clr.
REQ-034 alu_control SHALL be 00000 in every state that does not use the ALU.

Reset
REQ-035 clr high SHALL immediately force IDLE, all outputs 0, halted=0, regardless of current state, including mid-instruction or mid-wait.

Configuration
REQ-036 With CTRL_MEMWAIT_EN defined: T1, LD-T6, ST-T7 SHALL hold, strobes asserted, until mem_rdy sampled high; without it, each lasts exactly one cycle and mem_rdy is ignored.

Structure
REQ-037 Package ctrl_pkg SHALL hold state enum, opcode constants and ALU codes (ADD 00001, SUB 00010, AND 00011, OR 00100, INC 01111).
REQ-038 One sub-module ctrl_decode (opcode -> instruction class and ALU code) SHALL be used; no further hierarchy.

Verification
REQ-039 clr pulse mid-T4 -> all outputs 0 same cycle, IDLE next.
REQ-040 run=1, ir=0x69200071 (andi R2,R4,0x71) -> T3 Grb/Rout/Yen; T4 Cout, alu_control=00011; T5 ZLOout/Gra/Rin; T0 on cycle 7.
REQ-041 ir opcode 00000 (ld) -> T5 ZLOout+MARen, T6 Read+MDRen, T7 MDROut+Gra+Rin; 8 cycles.
REQ-042 ir opcode 11011 -> HALT after T2, halted=1 for 20 cycles with run toggling; clr returns IDLE.
REQ-043 CTRL_MEMWAIT_EN, mem_rdy low 3 cycles in T1 -> Read/MDRen held 4 cycles, then T2.
REQ-044 ir opcode 10111 (undefined) -> T2->T0, no Rin/Write asserted.
